// File: rtl/mem_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bist_pkg
//  Purpose  : Shared constants and state encoding for the March BIST engine.
//  Revision : 1.0  initial release
// ============================================================================
package mem_bist_pkg;

    localparam int          C_ADDR_W  = 6;
    localparam int          C_DATA_W  = 8;
    localparam logic [7:0]  C_PATTERN = 8'h55;

    localparam logic [2:0]  C_ST_IDLE = 3'd0;
    localparam logic [2:0]  C_ST_W0   = 3'd1;
    localparam logic [2:0]  C_ST_R0   = 3'd2;
    localparam logic [2:0]  C_ST_C0W1 = 3'd3;
    localparam logic [2:0]  C_ST_R1   = 3'd4;
    localparam logic [2:0]  C_ST_C1   = 3'd5;
    localparam logic [2:0]  C_ST_DONE = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE = C_ST_IDLE,
        ST_W0   = C_ST_W0,
        ST_R0   = C_ST_R0,
        ST_C0W1 = C_ST_C0W1,
        ST_R1   = C_ST_R1,
        ST_C1   = C_ST_C1,
        ST_DONE = C_ST_DONE
    } bist_state_t;

    // Phase lengths for the default 64-entry memory.
    localparam int C_W0_CYCLES   = 64;
    localparam int C_R0W1_CYCLES = 128;
    localparam int C_R1_CYCLES   = 128;
    localparam int C_BUSY_CYCLES = C_W0_CYCLES + C_R0W1_CYCLES + C_R1_CYCLES;

endpackage : mem_bist_pkg
`default_nettype wire

// File: rtl/mem_march_bist.sv
`default_nettype none
// ============================================================================
//  Module   : mem_march_bist
//  Purpose  : 3-phase March BIST initiator (W0; up R0/W1; down R1) for one
//             registered-read RAM port, reporting pass, first fail and count.
//  Revision : 1.0  initial release
// ============================================================================
module mem_march_bist
    import mem_bist_pkg::*;
#(
    parameter int                ADDR_W  = C_ADDR_W,
    parameter int                DATA_W  = C_DATA_W,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(C_PATTERN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [ADDR_W+1:0] err_count
);

    localparam int                CNT_W       = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] C_ADDR_LAST = '1;

    bist_state_t       r_state;
    bist_state_t       w_state_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [CNT_W-1:0]  r_err_count;

    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              w_we_nxt;
    logic              w_busy_nxt;
    logic              w_done_nxt;
    logic              w_pass_nxt;
    logic              w_clear;

    logic              w_cmp_en;
    logic [DATA_W-1:0] w_cmp_exp;
    logic              w_miscmp;

    // Read data is only meaningful in the cycle after a read request.
    always_comb begin
        w_cmp_en  = (r_state == ST_C0W1) || (r_state == ST_C1);
        w_cmp_exp = (r_state == ST_C1) ? ~PATTERN : PATTERN;
        w_miscmp  = w_cmp_en && (mem_rdata != w_cmp_exp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_we_nxt    = 1'b0;
        w_wdata_nxt = '0;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_pass_nxt  = r_pass;
        w_clear     = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_W0;
                    w_addr_nxt  = '0;
                    w_we_nxt    = 1'b1;
                    w_wdata_nxt = PATTERN;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_pass_nxt  = 1'b0;
                end else if (r_state == ST_DONE) begin
                    // Counter already includes the last C1 compare here.
                    w_done_nxt = 1'b1;
                    w_pass_nxt = (r_err_count == '0);
                end
            end

            ST_W0: begin
                if (r_addr == C_ADDR_LAST) begin
                    w_state_nxt = ST_R0;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_we_nxt    = 1'b1;
                    w_wdata_nxt = PATTERN;
                end
            end

            ST_R0: begin
                w_state_nxt = ST_C0W1;
                w_we_nxt    = 1'b1;
                w_wdata_nxt = ~PATTERN;
            end

            ST_C0W1: begin
                if (r_addr == C_ADDR_LAST) begin
                    w_state_nxt = ST_R1;
                end else begin
                    w_state_nxt = ST_R0;
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                end
            end

            ST_R1: begin
                w_state_nxt = ST_C1;
            end

            ST_C1: begin
                if (r_addr == '0) begin
                    w_state_nxt = ST_DONE;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_state_nxt = ST_R1;
                    w_addr_nxt  = r_addr - ADDR_W'(1);
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_we    <= w_we_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    // Error accumulator: saturating count, address latched on first miss.
    always_ff @(posedge clk) begin
        if (rst || w_clear) begin
            r_err_count <= '0;
            r_fail_addr <= '0;
        end else if (w_miscmp) begin
            if (r_err_count != '1) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
            if (r_err_count == '0) begin
                r_fail_addr <= r_addr;
            end
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = r_we;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign fail_addr = r_fail_addr;
    assign err_count = r_err_count;

endmodule : mem_march_bist
`default_nettype wire

// File: tb/tb_mem_march_bist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_march_bist
//  Purpose  : Self-checking bench for mem_march_bist with a faultable RAM.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_march_bist;

    localparam int         N    = 64;
    localparam logic [7:0] PAT  = 8'h55;
    localparam logic [7:0] PATN = 8'hAA;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       done;
    logic       pass;
    logic [5:0] fail_addr;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    mem_march_bist dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .err_count (err_count)
    );

    // Registered-read RAM with per-address stuck-at masks applied on write.
    logic [7:0] ram [N];
    logic [7:0] sa1 [N];
    logic [7:0] sa0 [N];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= (mem_wdata | sa1[mem_addr]) & ~sa0[mem_addr];
        mem_rdata <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] stored(input int a, input logic [7:0] v);
        return (v | sa1[a]) & ~sa0[a];
    endfunction

    // Miscompares visible by run cycle k: phase-2 read of A shows at 66+2A,
    // phase-3 read of A (descending) shows at 192+2*(63-A)+2.
    function automatic void exp_err_at(input int k, output int err, output int fa);
        int first_t;
        int t2;
        int t3;
        first_t = 1 << 30;
        err = 0;
        fa  = 0;
        for (int a = 0; a < N; a++) begin
            t2 = 64 + 2 * a + 2;
            t3 = 192 + 2 * (N - 1 - a) + 2;
            if (stored(a, PAT) != PAT && t2 <= k) begin
                err++;
                if (t2 < first_t) begin first_t = t2; fa = a; end
            end
            if (stored(a, PATN) != PATN && t3 <= k) begin
                err++;
                if (t3 < first_t) begin first_t = t3; fa = a; end
            end
        end
        if (err > 255) err = 255;
    endfunction

    logic mon_en = 1'b0;
    int   k = 0;
    int   busy_cnt = 0;
    int   first_done_k = -1;
    int   e_busy, e_done, e_pass, e_we, e_addr, e_wd, e_err, e_fa, j;

    always @(negedge clk) begin
        if (mon_en) begin
            exp_err_at(k, e_err, e_fa);
            e_busy = 0; e_done = 0; e_pass = 0; e_we = 0; e_addr = 0; e_wd = 0;
            if (k < 64) begin
                e_busy = 1; e_we = 1; e_addr = k; e_wd = PAT;
            end else if (k < 192) begin
                j = k - 64;
                e_busy = 1; e_addr = j / 2; e_we = j % 2; e_wd = (j % 2 == 1) ? PATN : 8'h00;
            end else if (k < 320) begin
                j = k - 192;
                e_busy = 1; e_addr = N - 1 - j / 2;
            end else if (k >= 321) begin
                e_done = 1; e_pass = (e_err == 0) ? 1 : 0;
            end
            chk("busy",      32'(busy),      e_busy);
            chk("done",      32'(done),      e_done);
            chk("pass",      32'(pass),      e_pass);
            chk("mem_we",    32'(mem_we),    e_we);
            chk("mem_addr",  32'(mem_addr),  e_addr);
            chk("mem_wdata", 32'(mem_wdata), e_wd);
            chk("err_count", 32'(err_count), e_err);
            chk("fail_addr", 32'(fail_addr), e_fa);
            if (k == 0)   chk("w0_first_wdata", 32'(mem_wdata), 32'h55);
            if (k == 65)  chk("c0w1_wdata",     32'(mem_wdata), 32'hAA);
            if (k == 192) chk("r1_first_addr",  32'(mem_addr),  32'd63);
            if (busy) busy_cnt++;
            if (done && first_done_k < 0) first_done_k = k;
            k++;
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},  32'(mem_addr),  0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_we"},    32'(mem_we),    0);
        chk({tag, "_busy"},  32'(busy),      0);
        chk({tag, "_done"},  32'(done),      0);
        chk({tag, "_pass"},  32'(pass),      0);
        chk({tag, "_fail"},  32'(fail_addr), 0);
        chk({tag, "_err"},   32'(err_count), 0);
    endtask

    task automatic begin_run();
        @(negedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0; busy_cnt = 0; first_done_k = -1;
        mon_en = 1'b1;
    endtask

    task automatic run_full(input bit poke);
        begin_run();
        for (int c = 0; c < 330; c++) begin
            @(negedge clk); #1;
            start = (poke && (c == 10 || c == 200)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk("busy_cycles", busy_cnt, 320);
        chk("done_cycle",  first_done_k, 321);
        mon_en = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < N; a++) begin ram[a] = 8'h00; sa1[a] = 8'h00; sa0[a] = 8'h00; end
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 1'b0;

        run_full(1'b0);
        chk("clean_pass", 32'(pass), 1);
        chk("clean_err",  32'(err_count), 0);
        chk("clean_fail", 32'(fail_addr), 0);

        sa1[42] = 8'h01;
        run_full(1'b0);
        chk("sa1_pass", 32'(pass), 0);
        chk("sa1_err",  32'(err_count), 1);
        chk("sa1_fail", 32'(fail_addr), 32'h2A);

        sa1[42] = 8'h00;
        sa0[5]  = 8'h80;
        sa0[48] = 8'h80;
        run_full(1'b0);
        chk("sa0x2_pass", 32'(pass), 0);
        chk("sa0x2_err",  32'(err_count), 2);
        chk("sa0x2_fail", 32'(fail_addr), 32'h30);

        run_full(1'b0);
        chk("rerun_pass", 32'(pass), 0);
        chk("rerun_err",  32'(err_count), 2);
        chk("rerun_fail", 32'(fail_addr), 32'h30);

        sa0[5]  = 8'h00;
        sa0[48] = 8'h00;
        run_full(1'b1);
        chk("poke_pass", 32'(pass), 1);

        // Phase-2 fault so counters are non-zero when reset hits.
        sa0[3] = 8'h01;
        begin_run();
        repeat (100) @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("pre_rst_err", 32'(err_count), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("midrst");
        rst = 1'b0;
        sa0[3] = 8'h00;
        run_full(1'b0);
        chk("post_rst_pass", 32'(pass), 1);
        chk("post_rst_err",  32'(err_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_march_bist
`default_nettype wire
